// File: rtl/nanorv32_uart_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nanorv32_uart_ctrl_pkg
// Shared definitions for the nanorv32 UART peripheral: peripheral bus address
// width, register offsets (as decoded from addr[3:2]), STATUS/CTRL bit indices,
// TX/RX state encodings and the STATUS word layout.
// -----------------------------------------------------------------------------
package nanorv32_uart_ctrl_pkg;

    // MSB of the byte address presented on the peripheral bus.
    localparam int NANORV32_PERIPH_ADDR_MSB = 7;

    // Register selects, i.e. byte offset >> 2.
    localparam logic [1:0] UART_REG_DATA   = 2'd0;   // 0x0
    localparam logic [1:0] UART_REG_STATUS = 2'd1;   // 0x4
    localparam logic [1:0] UART_REG_BAUD   = 2'd2;   // 0x8
    localparam logic [1:0] UART_REG_CTRL   = 2'd3;   // 0xC

    // STATUS bit indices.
    localparam int ST_TX_FULL      = 0;
    localparam int ST_TX_EMPTY     = 1;
    localparam int ST_TX_BUSY      = 2;
    localparam int ST_RX_VALID     = 3;
    localparam int ST_RX_OVERRUN   = 4;
    localparam int ST_RX_FRAME_ERR = 5;

    // CTRL bit indices.
    localparam int CTRL_TX_EN      = 0;
    localparam int CTRL_RX_EN      = 1;
    localparam int CTRL_IRQ_RX_EN  = 2;
    localparam int CTRL_IRQ_TXE_EN = 3;
    localparam int CTRL_W          = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Packed so that field order matches the STATUS bit positions (MSB first).
    typedef struct packed {
        logic rx_frame_err;
        logic rx_overrun;
        logic rx_valid;
        logic tx_busy;
        logic tx_empty;
        logic tx_full;
    } uart_status_t;

    function automatic logic [31:0] status_word(input uart_status_t st);
        return {26'b0, st};
    endfunction

endpackage

// File: rtl/nanorv32_uart_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// nanorv32_uart_ctrl_fifo
// Small synchronous FIFO used as the UART transmit queue.
//   clk, rst_n    : clock, asynchronous active-low reset (pointers only)
//   push_i/wdata_i: write request and data; ignored when full unless popping
//   pop_i         : remove head entry; ignored when empty
//   rdata_o       : current head entry (valid while !empty_o)
//   full_o/empty_o: occupancy flags
// Simultaneous push and pop is legal, including on a full FIFO (the pop frees
// the slot the push lands in).
// -----------------------------------------------------------------------------
module nanorv32_uart_ctrl_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Head is read combinationally so the consumer can load it on the very
    // edge it pops.
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/nanorv32_uart_ctrl.sv
// -----------------------------------------------------------------------------
// nanorv32_uart_ctrl
// 8N1 UART responder on the nanorv32 peripheral bus.
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus_uart_addr       : byte address, only [3:2] decoded
//   bus_uart_bytesel    : write byte lanes, 4'b0000 means read
//   bus_uart_din        : write data
//   bus_uart_en         : one-cycle access strobe
//   uart_bus_dout       : registered read data, held until the next read
//   uart_bus_ready_nxt  : zero-wait ready (follows bus_uart_en)
//   pad_uart_rx         : asynchronous serial input, idle high
//   uart_pad_tx         : serial output, idle high
//   uart_irq            : registered level interrupt
// Registers: 0x0 DATA, 0x4 STATUS (W1C overrun/frame), 0x8 BAUD, 0xC CTRL.
// One bit period is BAUD+1 clocks.
// -----------------------------------------------------------------------------
module nanorv32_uart_ctrl
    import nanorv32_uart_ctrl_pkg::*;
#(
    parameter int          TX_FIFO_DEPTH = 4,
    parameter logic [15:0] RESET_DIV     = 16'd0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NANORV32_PERIPH_ADDR_MSB:0] bus_uart_addr,
    input  logic [3:0]                        bus_uart_bytesel,
    input  logic [31:0]                       bus_uart_din,
    input  logic                              bus_uart_en,
    output logic [31:0]                       uart_bus_dout,
    output logic                              uart_bus_ready_nxt,
    input  logic                              pad_uart_rx,
    output logic                              uart_pad_tx,
    output logic                              uart_irq
);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [1:0] reg_sel;
    logic       wr_en;
    logic       rd_en;
    logic       data_rd;
    logic       data_push;
    logic       status_w1c;

    assign reg_sel    = bus_uart_addr[3:2];
    assign wr_en      = bus_uart_en & (|bus_uart_bytesel);
    assign rd_en      = bus_uart_en & ~(|bus_uart_bytesel);
    assign data_rd    = rd_en & (reg_sel == UART_REG_DATA);
    assign data_push  = wr_en & (reg_sel == UART_REG_DATA) & bus_uart_bytesel[0];
    assign status_w1c = wr_en & (reg_sel == UART_REG_STATUS) & bus_uart_bytesel[0];

    assign uart_bus_ready_nxt = bus_uart_en;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus_uart_addr[NANORV32_PERIPH_ADDR_MSB:4], bus_uart_addr[1:0],
                               bus_uart_din[31:16], bus_uart_bytesel[3:2]};

    // ------------------------------------------------------------------
    // BAUD / CTRL registers
    // ------------------------------------------------------------------
    logic [15:0]       baud_q;
    logic [CTRL_W-1:0] ctrl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q <= RESET_DIV;
            ctrl_q <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                UART_REG_BAUD: begin
                    if (bus_uart_bytesel[0]) baud_q[7:0]  <= bus_uart_din[7:0];
                    if (bus_uart_bytesel[1]) baud_q[15:8] <= bus_uart_din[15:8];
                end
                UART_REG_CTRL: begin
                    if (bus_uart_bytesel[0]) ctrl_q <= bus_uart_din[CTRL_W-1:0];
                end
                default: ;
            endcase
        end
    end

    logic tx_en;
    logic rx_en;
    logic irq_rx_en;
    logic irq_txe_en;

    assign tx_en      = ctrl_q[CTRL_TX_EN];
    assign rx_en      = ctrl_q[CTRL_RX_EN];
    assign irq_rx_en  = ctrl_q[CTRL_IRQ_RX_EN];
    assign irq_txe_en = ctrl_q[CTRL_IRQ_TXE_EN];

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       tx_pop;

    nanorv32_uart_ctrl_fifo #(
        .DEPTH (TX_FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (data_push),
        .wdata_i (bus_uart_din[7:0]),
        .pop_i   (tx_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ------------------------------------------------------------------
    // TX shifter
    // ------------------------------------------------------------------
    tx_state_e   tx_state_q;
    logic [15:0] tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_shift_q;
    logic        tx_line_q;
    logic        tx_cnt_zero;

    assign tx_cnt_zero = (tx_cnt_q == 16'd0);

    // A new frame starts from IDLE, or straight out of the last stop-bit
    // clock so consecutive bytes leave no idle gap.
    assign tx_pop = tx_en & ~fifo_empty &
                    ((tx_state_q == TX_IDLE) | ((tx_state_q == TX_STOP) & tx_cnt_zero));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_state_q <= TX_START;
                        tx_cnt_q   <= baud_q;
                        tx_shift_q <= fifo_head;
                        tx_line_q  <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt_zero) begin
                        tx_state_q <= TX_DATA;
                        tx_cnt_q   <= baud_q;
                        tx_bit_q   <= '0;
                        tx_line_q  <= tx_shift_q[0];
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_zero) begin
                        tx_cnt_q <= baud_q;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= TX_STOP;
                            tx_line_q  <= 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_line_q  <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_zero) begin
                        if (tx_pop) begin
                            tx_state_q <= TX_START;
                            tx_cnt_q   <= baud_q;
                            tx_shift_q <= fifo_head;
                            tx_line_q  <= 1'b0;
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign uart_pad_tx = tx_line_q;

    // ------------------------------------------------------------------
    // RX synchroniser and sampler
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;
    logic rx_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= pad_uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_sync_q;

    rx_state_e   rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic        rx_cnt_zero;
    logic        rx_stop_sample;
    logic        rx_byte_done;
    logic        rx_frame_bad;

    assign rx_cnt_zero    = (rx_cnt_q == 16'd0);
    assign rx_stop_sample = rx_en & (rx_state_q == RX_STOP) & rx_cnt_zero;
    assign rx_byte_done   = rx_stop_sample & rx_sync_q;
    assign rx_frame_bad   = rx_stop_sample & ~rx_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else if (!rx_en) begin
            rx_state_q <= RX_IDLE;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    // Half a period to land the later samples mid-bit.
                    if (rx_fall) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= {1'b0, baud_q[15:1]};
                    end
                end
                RX_START: begin
                    if (rx_cnt_zero) begin
                        if (rx_sync_q) begin
                            rx_state_q <= RX_IDLE;   // glitch, not a start bit
                        end else begin
                            rx_state_q <= RX_DATA;
                            rx_cnt_q   <= baud_q;
                            rx_bit_q   <= '0;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_zero) begin
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_cnt_q   <= baud_q;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_zero) begin
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX holding register and sticky error flags
    // ------------------------------------------------------------------
    logic [7:0] rx_byte_q,  rx_byte_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_ovr_q,   rx_ovr_d;
    logic       rx_ferr_q,  rx_ferr_d;

    // Ordering matters: W1C first, then the DATA read, then new events, so a
    // flag raised in the same cycle it is cleared is not lost, and a byte
    // completing during a DATA read replaces the one being read out.
    always_comb begin
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        rx_ferr_d  = rx_ferr_q;
        if (status_w1c) begin
            if (bus_uart_din[ST_RX_OVERRUN])   rx_ovr_d  = 1'b0;
            if (bus_uart_din[ST_RX_FRAME_ERR]) rx_ferr_d = 1'b0;
        end
        if (data_rd) begin
            rx_valid_d = 1'b0;
        end
        if (rx_byte_done) begin
            if (!rx_valid_q || data_rd) begin
                rx_byte_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end else begin
                rx_ovr_d = 1'b1;
            end
        end
        if (rx_frame_bad) begin
            rx_ferr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // ------------------------------------------------------------------
    // Status, read data, interrupt
    // ------------------------------------------------------------------
    uart_status_t status;
    logic         tx_busy;
    logic         irq_d;
    logic         irq_q;
    logic [31:0]  dout_q;

    assign tx_busy = (tx_state_q != TX_IDLE);

    always_comb begin
        status.tx_full      = fifo_full;
        status.tx_empty     = fifo_empty;
        status.tx_busy      = tx_busy;
        status.rx_valid     = rx_valid_q;
        status.rx_overrun   = rx_ovr_q;
        status.rx_frame_err = rx_ferr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_en) begin
            case (reg_sel)
                UART_REG_DATA:   dout_q <= {24'b0, rx_byte_q};
                UART_REG_STATUS: dout_q <= status_word(status);
                UART_REG_BAUD:   dout_q <= {16'b0, baud_q};
                UART_REG_CTRL:   dout_q <= {{(32-CTRL_W){1'b0}}, ctrl_q};
                default:         dout_q <= '0;
            endcase
        end
    end

    assign irq_d = (irq_rx_en & rx_valid_q) | (irq_txe_en & fifo_empty & ~tx_busy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign uart_bus_dout = dout_q;
    assign uart_irq      = irq_q;

endmodule

// File: tb/tb_nanorv32_uart_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nanorv32_uart_ctrl
// Scenario tasks exercising the UART through its bus interface. Expected serial
// waveforms come from the 8N1 frame definition (start 0, data LSB first,
// stop 1, BAUD+1 clocks per bit); expected STATUS words come from the flag map.
// -----------------------------------------------------------------------------
module tb_nanorv32_uart_ctrl;
    import nanorv32_uart_ctrl_pkg::*;

    logic                              clk = 1'b0;
    logic                              rst_n;
    logic [NANORV32_PERIPH_ADDR_MSB:0] addr;
    logic [3:0]                        bsel;
    logic [31:0]                       din;
    logic                              en;
    logic [31:0]                       dout;
    logic                              ready_nxt;
    logic                              rx_drv;
    logic                              lb;
    logic                              pad_rx;
    logic                              tx;
    logic                              irq;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    // Loopback wires the serial output straight back to the input.
    assign pad_rx = lb ? tx : rx_drv;

    nanorv32_uart_ctrl #(
        .TX_FIFO_DEPTH (4),
        .RESET_DIV     (16'd0)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .bus_uart_addr      (addr),
        .bus_uart_bytesel   (bsel),
        .bus_uart_din       (din),
        .bus_uart_en        (en),
        .uart_bus_dout      (dout),
        .uart_bus_ready_nxt (ready_nxt),
        .pad_uart_rx        (pad_rx),
        .uart_pad_tx        (tx),
        .uart_irq           (irq)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // STATUS word from the individual flags.
    function automatic logic [31:0] st(input bit full, input bit empty, input bit busy,
                                        input bit valid, input bit ovr, input bit ferr);
        return 32'(full) * 1 + 32'(empty) * 2 + 32'(busy) * 4 +
               32'(valid) * 8 + 32'(ovr) * 16 + 32'(ferr) * 32;
    endfunction

    // Bus tasks: called on a negedge, return on the negedge after the access edge.
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] bs);
        addr = a; din = d; bsel = bs; en = 1'b1;
        @(negedge clk);
        en = 1'b0; bsel = 4'b0000;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        addr = a; bsel = 4'b0000; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        d = dout;
    endtask

    task automatic check_status(input logic [31:0] expv, input string name);
        logic [31:0] s;
        bus_read(8'h04, s);
        total++;
        if (s !== expv) begin
            bad++;
            $display("FAIL %s: STATUS=0x%08h required 0x%08h", name, s, expv);
        end
    endtask

    // Samples the tx line mid-bit for every byte in exp_q, back to back.
    task automatic check_tx_stream(input int period, input string name, output int lat);
        int          waited;
        logic [9:0]  obs;
        logic [9:0]  expv;
        logic [7:0]  b;
        waited = 0;
        while (tx !== 1'b0 && waited < 64 * period) begin
            @(negedge clk);
            waited++;
        end
        lat = waited;
        total++;
        if (tx !== 1'b0) begin
            bad++;
            $display("FAIL %s start: tx=%b required 0", name, tx);
            exp_q.delete();
        end else begin
            repeat (period / 2) @(negedge clk);
            while (exp_q.size() > 0) begin
                b    = exp_q.pop_front();
                expv = {1'b1, b, 1'b0};
                for (int k = 0; k < 10; k++) begin
                    obs[k] = tx;
                    repeat (period) @(negedge clk);
                end
                total++;
                if (obs !== expv) begin
                    bad++;
                    $display("FAIL %s frame 0x%02h: line=%b required %b", name, b, obs, expv);
                end else begin
                    $display("tx %s byte 0x%02h ok", name, b);
                end
            end
        end
    endtask

    task automatic wait_rx_valid(input int limit, input string name);
        logic [31:0] s;
        int          n;
        n = 0;
        do begin
            bus_read(8'h04, s);
            n++;
        end while (!s[ST_RX_VALID] && n < limit);
        total++;
        if (!s[ST_RX_VALID]) begin
            bad++;
            $display("FAIL %s: rx_valid=%b required 1 within %0d reads", name, s[ST_RX_VALID], limit);
        end
    endtask

    task automatic send_serial(input logic [7:0] b, input logic stop, input int period);
        rx_drv = 1'b0;
        repeat (period) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_drv = b[k];
            repeat (period) @(negedge clk);
        end
        rx_drv = stop;
        repeat (period) @(negedge clk);
        rx_drv = 1'b1;
        repeat (period) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0; en = 1'b0; bsel = '0; addr = '0; din = '0; rx_drv = 1'b1; lb = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (tx !== 1'b1 || dout !== 32'h0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: tx=%b dout=0x%08h irq=%b required 1/0/0", tx, dout, irq);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (ready_nxt !== 1'b0) begin
            bad++;
            $display("FAIL ready_idle: ready=%b required 0", ready_nxt);
        end
        addr = 8'h04; bsel = 4'b0000; en = 1'b1;
        #1;
        total++;
        if (ready_nxt !== 1'b1) begin
            bad++;
            $display("FAIL ready_en: ready=%b required 1", ready_nxt);
        end
        @(negedge clk);
        en = 1'b0;
        total++;
        if (dout !== st(0, 1, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL reset_status: STATUS=0x%08h required 0x00000002", dout);
        end
        bus_read(8'h08, d);
        bus_read(8'h0C, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL reset_ctrl: CTRL=0x%08h required 0", d);
        end
        $display("reset checks done");
    endtask

    task automatic test_tx_basic();
        int lat;
        bus_write(8'h08, 32'd3, 4'b0011);
        bus_write(8'h0C, 32'd1, 4'b0001);
        exp_q.push_back(8'hA5);
        bus_write(8'h00, 32'hA5, 4'b0001);
        check_tx_stream(4, "basic", lat);
        total++;
        if (lat != 1) begin
            bad++;
            $display("FAIL tx_start_latency: %0d clk required 1", lat);
        end
        check_status(st(0, 1, 0, 0, 0, 0), "tx_idle_after_frame");
    endtask

    task automatic test_tx_random();
        int          lat;
        int          bd;
        logic [7:0]  b;
        for (int i = 0; i < 3; i++) begin
            bd = $urandom_range(6, 1);
            b  = 8'($urandom);
            bus_write(8'h08, 32'(bd), 4'b0011);
            exp_q.push_back(b);
            bus_write(8'h00, {24'h0, b}, 4'b0001);
            check_tx_stream(bd + 1, "random", lat);
            repeat (bd + 1) @(negedge clk);
        end
    endtask

    task automatic test_fifo_full();
        int lat;
        bus_write(8'h0C, 32'd0, 4'b0001);
        bus_write(8'h08, 32'd3, 4'b0011);
        for (int i = 1; i <= 5; i++) begin
            bus_write(8'h00, 32'(i), 4'b0001);
            if (i <= 4) exp_q.push_back(8'(i));
        end
        check_status(st(1, 0, 0, 0, 0, 0), "fifo_full");
        bus_write(8'h0C, 32'd1, 4'b0001);
        check_tx_stream(4, "fifo_drain", lat);
        check_status(st(0, 1, 0, 0, 0, 0), "fifo_drained");
    endtask

    task automatic test_back_to_back();
        int         lat;
        logic [7:0] b;
        bus_write(8'h0C, 32'd0, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            bus_write(8'h00, {24'h0, b}, 4'b0001);
        end
        // Enable, then push on the edge the first pop happens (FIFO full).
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_write(8'h0C, 32'd1, 4'b0001);
        bus_write(8'h00, {24'h0, b}, 4'b0001);
        check_tx_stream(4, "push_pop_full", lat);
        check_status(st(0, 1, 0, 0, 0, 0), "push_pop_done");
    endtask

    task automatic test_loopback();
        logic [31:0] d;
        logic [7:0]  b;
        int          bd;
        lb = 1'b1;
        bus_write(8'h08, 32'd7, 4'b0011);
        bus_write(8'h0C, 32'd3, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            b = (i == 0) ? 8'h3C : 8'($urandom);
            if (i > 0) begin
                bd = $urandom_range(10, 3);
                bus_write(8'h08, 32'(bd), 4'b0011);
            end
            bus_write(8'h00, {24'h0, b}, 4'b0001);
            wait_rx_valid(600, "loopback_valid");
            bus_read(8'h00, d);
            total++;
            if (d !== {24'h0, b}) begin
                bad++;
                $display("FAIL loopback_data: DATA=0x%08h required 0x%08h", d, {24'h0, b});
            end else begin
                $display("rx loopback byte 0x%02h ok", b);
            end
            bus_read(8'h04, d);
            total++;
            if (d[ST_RX_VALID] !== 1'b0) begin
                bad++;
                $display("FAIL loopback_clear: rx_valid=%b required 0", d[ST_RX_VALID]);
            end
            repeat (150) @(negedge clk);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        logic [7:0]  b1;
        logic [7:0]  b2;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        bus_write(8'h08, 32'd7, 4'b0011);
        bus_write(8'h00, {24'h0, b1}, 4'b0001);
        bus_write(8'h00, {24'h0, b2}, 4'b0001);
        repeat (220) @(negedge clk);
        check_status(st(0, 1, 0, 1, 1, 0), "overrun_set");
        bus_read(8'h00, d);
        total++;
        if (d !== {24'h0, b1}) begin
            bad++;
            $display("FAIL overrun_data: DATA=0x%08h required 0x%08h", d, {24'h0, b1});
        end
        bus_write(8'h04, 32'h10, 4'b0001);
        check_status(st(0, 1, 0, 0, 0, 0), "overrun_w1c");
        lb = 1'b0;
    endtask

    task automatic test_false_start_and_frame();
        bus_write(8'h0C, 32'd2, 4'b0001);
        bus_write(8'h08, 32'd7, 4'b0011);
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check_status(st(0, 1, 0, 0, 0, 0), "false_start");
        send_serial(8'($urandom), 1'b0, 8);
        repeat (4) @(negedge clk);
        check_status(st(0, 1, 0, 0, 0, 1), "frame_err");
        bus_write(8'h04, 32'h20, 4'b0001);
        check_status(st(0, 1, 0, 0, 0, 0), "frame_err_w1c");
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic [7:0]  b;
        int          n;
        b = 8'($urandom);
        bus_write(8'h0C, 32'h6, 4'b0001);
        @(negedge clk);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_idle: irq=%b required 0", irq);
        end
        send_serial(b, 1'b1, 8);
        n = 0;
        while (irq !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_rx: irq=%b required 1", irq);
        end
        bus_read(8'h00, d);
        total++;
        if (d !== {24'h0, b} || irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_read: DATA=0x%08h irq=%b required 0x%08h/1", d, irq, {24'h0, b});
        end
        @(negedge clk);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_clear_delay: irq=%b required 0", irq);
        end
        bus_write(8'h0C, 32'h8, 4'b0001);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_txe_early: irq=%b required 0", irq);
        end
        @(negedge clk);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_txe: irq=%b required 1", irq);
        end
        bus_write(8'h0C, 32'h0, 4'b0001);
        @(negedge clk);
        $display("irq checks done");
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        int          lows;
        bus_write(8'h08, 32'd7, 4'b0011);
        bus_write(8'h0C, 32'd1, 4'b0001);
        bus_write(8'h00, 32'h00, 4'b0001);
        bus_read(8'h08, d);
        repeat (20) @(negedge clk);
        total++;
        if (tx !== 1'b0) begin
            bad++;
            $display("FAIL mid_frame_line: tx=%b required 0", tx);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (tx !== 1'b1 || dout !== 32'h0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: tx=%b dout=0x%08h irq=%b required 1/0/0", tx, dout, irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_status(st(0, 1, 0, 0, 0, 0), "status_after_reset");
        bus_read(8'h08, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL baud_after_reset: BAUD=0x%08h required 0", d);
        end
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        total++;
        if (lows != 0) begin
            bad++;
            $display("FAIL tx_quiet_after_reset: %0d low samples required 0", lows);
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_random();
        test_fifo_full();
        test_back_to_back();
        test_loopback();
        test_overrun();
        test_false_start_and_frame();
        test_irq();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
